cpc_bus_arbiter: RTL
====================

CPC_BUS_ARBITER -- requirements
Module: cpc_bus_arbiter

Interface
REQ-001 Parameter CPU_SLOT, default 8: phase at which a CPU memory access window opens.
REQ-002 Parameter ACC_CYC, default 3: length of the CPU access window in clk cycles.
REQ-003 Parameter VID_CYC, default 3: length of the video access window in clk cycles, starting at phase 0.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  Z80 bus strobes, active-low.
REQ-007 cpu_addr  in  16  Z80 address bus.
REQ-008 vid_req  in  1  video fetch request, sampled at phase 15.
REQ-009 vid_addr  in  16  video fetch address, held while vid_req is high.
REQ-010 wait_n  out  1  Z80 WAIT, active-low, registered.
REQ-011 ram_addr  out  16  shared RAM address.
REQ-012 ram_oe, ram_we  out  1 each  RAM read and write strobes, active-high, registered.
REQ-013 vid_ack  out  1  one-cycle pulse meaning video data is valid on the RAM bus.
REQ-014 phase  out  4  current slot phase.

Function
REQ-015 phase SHALL increment on every clk and wrap from 15 to 0.
REQ-016 Legal parameters SHALL satisfy VID_CYC <= CPU_SLOT and CPU_SLOT+ACC_CYC <= 16; an elaboration check SHALL reject any other combination.
REQ-017 A CPU memory request SHALL be: mreq_n=0, rfsh_n=1, and (rd_n=0 or wr_n=0).
REQ-018 Refresh cycles (rfsh_n=0) and I/O cycles (iorq_n=0) SHALL never drive wait_n low or touch RAM.
REQ-019 The CPU FSM SHALL have the states IDLE, WAITSLOT, ACCESS and DONE.
REQ-020 IDLE→ACCESS SHALL occur when a request is present on an edge where phase==CPU_SLOT-1; in every other case a request SHALL move IDLE→WAITSLOT.
REQ-021 WAITSLOT→ACCESS SHALL occur on the edge where phase==CPU_SLOT-1.
REQ-022 While in WAITSLOT, and on the edge entering it, wait_n SHALL be 0.
REQ-023 ACCESS SHALL last exactly ACC_CYC cycles.
REQ-024 In ACCESS, ram_addr SHALL equal cpu_addr, ram_oe SHALL equal !rd_n, ram_we SHALL equal !wr_n, and wait_n SHALL be 0 except in the final ACCESS cycle, where it SHALL be 1.
REQ-025 ACCESS→DONE SHALL occur after the final ACCESS cycle; in DONE, ram_oe=ram_we=0 and wait_n=1.
REQ-026 DONE→IDLE SHALL occur when mreq_n=1, giving exactly one RAM access per Z80 cycle.
REQ-027 If mreq_n rises in WAITSLOT or ACCESS (aborted cycle), the FSM SHALL return to IDLE on the next edge, with wait_n=1 and ram_we=0.
REQ-028 Video: if vid_req=1 at phase 15, phases 0..VID_CYC-1 SHALL drive ram_addr=vid_addr and ram_oe=1, keep ram_we=0, and pulse vid_ack at phase VID_CYC-1.
REQ-029 If vid_req=0 at phase 15, the video window SHALL stay idle (ram_oe=0); the CPU SHALL still wait for its own slot.
REQ-030 Video and CPU windows SHALL never overlap, so no dynamic priority is needed.
REQ-031 Outside any active window, ram_addr SHALL hold its last value.
REQ-032 Worst-case wait insertion SHALL be 15+ACC_CYC-1 cycles.

Reset
REQ-033 With reset_n=0 at an edge, the block SHALL set: phase=0, FSM=IDLE, wait_n=1, ram_oe=0, ram_we=0, vid_ack=0, ram_addr=0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the access within one cycle, with no residual write strobe.

Structure
REQ-035 A shared package cpc_bus_pkg SHALL hold the FSM state enum, PHASE_W=4 and the default CPU_SLOT/ACC_CYC/VID_CYC constants.
REQ-036 Sub-module cpc_phase_gen SHALL be the 4-bit wrapping phase counter and SHALL provide decoded strobes for phase 15 and phase CPU_SLOT-1.

Verification
REQ-037 Read, mreq_n/rd_n low at phase 2 → wait_n=0 from phase 3, ACCESS at phases 8-10 with ram_oe=1 and ram_addr=cpu_addr, wait_n=1 at phase 10, DONE until mreq_n high.
REQ-038 Request at phase 7 (CPU_SLOT-1 edge) → ACCESS at phase 8 with no wait inserted before it; ram_we=1 for a write of addr 0xC000.
REQ-039 vid_req=1, vid_addr=0x4000 at phase 15 → ram_oe=1, ram_addr=0x4000 at phases 0-2, vid_ack only at phase 2, ram_we=0 throughout; a concurrent CPU request is held until phase 8.
REQ-040 Refresh cycle (mreq_n=0, rfsh_n=0) and OUT cycle (iorq_n=0) → wait_n stays 1, ram_oe=ram_we=0.
REQ-041 reset_n=0 during ACCESS of a write → next cycle ram_we=0, wait_n=1, phase=0; mreq_n released in WAITSLOT → IDLE next edge.
REQ-042 1000 random CPU/video requests → assertions: never ram_we in a video window, never overlapping windows, exactly one ACCESS per mreq_n low period, wait_n low at most 17 cycles.

Source files
------------

// File: rtl/cpc_bus_arbiter_pkg.sv
// Shared types and defaults for the CPC-style Z80/video shared-RAM arbiter.
package cpc_bus_pkg;

    localparam int PHASE_W      = 4;
    localparam int DEF_CPU_SLOT = 8;
    localparam int DEF_ACC_CYC  = 3;
    localparam int DEF_VID_CYC  = 3;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_WAITSLOT,
        CPU_ACCESS,
        CPU_DONE
    } cpu_state_e;

endpackage

// File: rtl/cpc_bus_arbiter_if.sv
// Z80 bus, video fetch port and shared-RAM side of the arbiter, bundled as one interface.
interface cpc_bus_arbiter_if;
    import cpc_bus_pkg::*;

    logic               mreq_n;
    logic               iorq_n;
    logic               rd_n;
    logic               wr_n;
    logic               m1_n;
    logic               rfsh_n;
    logic [15:0]        cpu_addr;
    logic               vid_req;
    logic [15:0]        vid_addr;
    logic               wait_n;
    logic [15:0]        ram_addr;
    logic               ram_oe;
    logic               ram_we;
    logic               vid_ack;
    logic [PHASE_W-1:0] phase;

    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, cpu_addr, vid_req, vid_addr,
        input  wait_n, ram_addr, ram_oe, ram_we, vid_ack, phase
    );

    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, cpu_addr, vid_req, vid_addr,
        output wait_n, ram_addr, ram_oe, ram_we, vid_ack, phase
    );

endinterface

// File: rtl/cpc_bus_arbiter_phase_gen.sv
// Free-running 16-slot phase counter with decoded strobes for the video sample and CPU slot edges.
module cpc_phase_gen
    import cpc_bus_pkg::*;
#(
    parameter int CPU_SLOT = DEF_CPU_SLOT
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PHASE_W-1:0] phase_o,
    output logic               last_o,
    output logic               slot_pre_o
);

    localparam logic [PHASE_W-1:0] SLOT_PRE = PHASE_W'(CPU_SLOT - 1);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    assign phase_d = phase_q + PHASE_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o    = phase_q;
    assign last_o     = (phase_q == '1);
    assign slot_pre_o = (phase_q == SLOT_PRE);

endmodule

// File: rtl/cpc_bus_arbiter.sv
// Time-sliced shared-RAM arbiter: fixed video window at phase 0, fixed CPU window at CPU_SLOT,
// Z80 held in WAIT until its slot comes round.
//
// state        | meaning
// CPU_IDLE     | no Z80 memory cycle pending
// CPU_WAITSLOT | request seen, WAIT asserted until the CPU slot opens
// CPU_ACCESS   | RAM driven from the Z80 bus for ACC_CYC cycles
// CPU_DONE     | access finished, waiting for MREQ to end the Z80 cycle
module cpc_bus_arbiter
    import cpc_bus_pkg::*;
#(
    parameter int CPU_SLOT = DEF_CPU_SLOT,
    parameter int ACC_CYC  = DEF_ACC_CYC,
    parameter int VID_CYC  = DEF_VID_CYC
) (
    input  logic               clk,
    input  logic               reset_n,
    cpc_bus_arbiter_if.slave   bus
);

    if (VID_CYC < 1 || ACC_CYC < 1 || VID_CYC > CPU_SLOT || CPU_SLOT + ACC_CYC > 16) begin : g_bad_params
        $error("cpc_bus_arbiter: video and CPU windows must fit in 16 phases without overlap");
    end

    localparam logic [PHASE_W-1:0] ACC_LOAD = PHASE_W'(ACC_CYC - 1);
    localparam logic [PHASE_W-1:0] VID_LOAD = PHASE_W'(VID_CYC - 1);

    logic [PHASE_W-1:0] phase;
    logic               phase_last;
    logic               slot_pre;

    cpc_phase_gen #(.CPU_SLOT(CPU_SLOT)) u_phase_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase_o    (phase),
        .last_o     (phase_last),
        .slot_pre_o (slot_pre)
    );

    cpu_state_e         state_q,    state_d;
    logic [PHASE_W-1:0] acc_cnt_q,  acc_cnt_d;
    logic [PHASE_W-1:0] vid_cnt_q,  vid_cnt_d;
    logic               vid_busy_q, vid_busy_d;
    logic               wait_n_q,   wait_n_d;
    logic               ram_oe_q,   ram_oe_d;
    logic               ram_we_q,   ram_we_d;
    logic               vid_ack_q,  vid_ack_d;
    logic [15:0]        ram_addr_q, ram_addr_d;
    logic               cpu_acc_d;
    logic               cpu_req;
    logic               unused_m1;

    // Opcode fetches arbitrate exactly like data reads.
    assign unused_m1 = bus.m1_n;

    // Refresh and I/O cycles are excluded here so they can never stall the Z80.
    assign cpu_req = !bus.mreq_n && bus.iorq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        vid_busy_d = vid_busy_q;
        vid_cnt_d  = vid_cnt_q;

        case (state_q)
            CPU_IDLE: begin
                if (cpu_req) begin
                    if (slot_pre) begin
                        state_d   = CPU_ACCESS;
                        acc_cnt_d = ACC_LOAD;
                    end else begin
                        state_d = CPU_WAITSLOT;
                    end
                end
            end
            CPU_WAITSLOT: begin
                if (bus.mreq_n) begin
                    state_d = CPU_IDLE;
                end else if (slot_pre) begin
                    state_d   = CPU_ACCESS;
                    acc_cnt_d = ACC_LOAD;
                end
            end
            CPU_ACCESS: begin
                if (bus.mreq_n) begin
                    state_d = CPU_IDLE;
                end else if (acc_cnt_q == '0) begin
                    state_d = CPU_DONE;
                end else begin
                    acc_cnt_d = acc_cnt_q - PHASE_W'(1);
                end
            end
            CPU_DONE: begin
                if (bus.mreq_n) begin
                    state_d = CPU_IDLE;
                end
            end
            default: state_d = CPU_IDLE;
        endcase

        if (phase_last) begin
            vid_busy_d = bus.vid_req;
            vid_cnt_d  = VID_LOAD;
        end else if (vid_busy_q) begin
            if (vid_cnt_q == '0) begin
                vid_busy_d = 1'b0;
            end else begin
                vid_cnt_d = vid_cnt_q - PHASE_W'(1);
            end
        end

        // Outputs are registered, so they are decoded from the next state.
        cpu_acc_d  = (state_d == CPU_ACCESS);
        wait_n_d   = !((state_d == CPU_WAITSLOT) || (cpu_acc_d && acc_cnt_d != '0));
        ram_oe_d   = vid_busy_d || (cpu_acc_d && !bus.rd_n);
        ram_we_d   = cpu_acc_d && !bus.wr_n;
        vid_ack_d  = vid_busy_d && (vid_cnt_d == '0);
        ram_addr_d = ram_addr_q;
        if (vid_busy_d) begin
            ram_addr_d = bus.vid_addr;
        end else if (cpu_acc_d) begin
            ram_addr_d = bus.cpu_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CPU_IDLE;
            acc_cnt_q  <= '0;
            vid_cnt_q  <= '0;
            vid_busy_q <= 1'b0;
            wait_n_q   <= 1'b1;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            vid_ack_q  <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            vid_cnt_q  <= vid_cnt_d;
            vid_busy_q <= vid_busy_d;
            wait_n_q   <= wait_n_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            vid_ack_q  <= vid_ack_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign bus.wait_n   = wait_n_q;
    assign bus.ram_oe   = ram_oe_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.vid_ack  = vid_ack_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.phase    = phase;

endmodule
